// File: rtl/apb_timer_slave.sv
// Purpose: APB slave exposing CTRL/LOAD/COUNT/STATUS around a prescaled down-counter with a level irq.
// Latency: every access completes WAIT_STATES cycles after ACCESS entry; irq follows expired by one cycle.
// Backpressure: pready held low for WAIT_STATES ACCESS cycles, high whenever the slave is not selected.
module apb_timer_slave #(
    parameter int WAIT_STATES = 1
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq
);

    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LOAD   = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    logic [2:0]  wait_cnt;
    logic [7:0]  offset;
    logic        setup_ph;
    logic        access_ph;
    logic        xfer_done;
    logic        off_ok;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic [31:0] rd_val;

    logic        ctrl_en;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [7:0]  ctrl_prescale;
    logic [7:0]  presc_cnt;
    logic [31:0] load_val;
    logic [31:0] count_val;
    logic        expired;
    logic        tick;
    logic        expire;

    // Upper address bits are deliberately not decoded; registers alias every 256 bytes.
    logic        unused_paddr;
    assign unused_paddr = ^paddr[11:8];

    assign offset    = paddr[7:0];
    assign setup_ph  = psel & ~penable;
    assign access_ph = psel & penable;
    // A transfer never completes under reset, so an in-flight write is dropped.
    assign xfer_done = access_ph & (wait_cnt == 3'd0) & ~preset;

    assign wr_ctrl   = xfer_done & pwrite & (offset == OFF_CTRL);
    assign wr_load   = xfer_done & pwrite & (offset == OFF_LOAD);
    assign wr_status = xfer_done & pwrite & (offset == OFF_STATUS);

    assign tick   = ctrl_en & (presc_cnt == ctrl_prescale);
    assign expire = tick & (count_val == 32'd0);

    // Address decode and read mux; COUNT reflects the value before this cycle's tick.
    always_comb begin
        rd_val = 32'h0;
        off_ok = 1'b1;
        case (offset)
            OFF_CTRL:   rd_val = {16'h0, ctrl_prescale, 5'h0, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
            OFF_LOAD:   rd_val = load_val;
            OFF_COUNT:  rd_val = count_val;
            OFF_STATUS: rd_val = {31'h0, expired};
            default:    off_ok = 1'b0;
        endcase
    end

    // Bus outputs: idle-safe defaults, data and error only in the completion cycle.
    always_comb begin
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h0;
        if (!preset) begin
            if (access_ph) begin
                pready = (wait_cnt == 3'd0);
            end
            if (xfer_done) begin
                pslverr = ~off_ok;
                if (!pwrite && off_ok) begin
                    prdata = rd_val;
                end
            end
        end
    end

    // Wait-state counter: armed in SETUP, counts down through ACCESS; holds if psel drops.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt <= 3'd0;
        end else if (setup_ph) begin
            wait_cnt <= WAIT_INIT;
        end else if (access_ph && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Control register; a one-shot expiry turns the timer off unless software rewrites CTRL.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_prescale    <= 8'h0;
        end else if (wr_ctrl) begin
            ctrl_en          <= pwdata[0];
            ctrl_auto_reload <= pwdata[1];
            ctrl_irq_en      <= pwdata[2];
            ctrl_prescale    <= pwdata[15:8];
        end else if (expire && !ctrl_auto_reload) begin
            ctrl_en <= 1'b0;
        end
    end

    // Reload value register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            load_val <= 32'h0;
        end else if (wr_load) begin
            load_val <= pwdata;
        end
    end

    // Down-counter; a LOAD write takes priority over the tick update.
    always_ff @(posedge pclk) begin
        if (preset) begin
            count_val <= 32'h0;
        end else if (wr_load) begin
            count_val <= pwdata;
        end else if (tick) begin
            if (count_val != 32'd0) begin
                count_val <= count_val - 32'd1;
            end else if (ctrl_auto_reload) begin
                count_val <= load_val;
            end
        end
    end

    // Prescaler: runs only while enabled, wraps to 0 on each tick, restarts on LOAD.
    always_ff @(posedge pclk) begin
        if (preset) begin
            presc_cnt <= 8'h0;
        end else if (wr_load) begin
            presc_cnt <= 8'h0;
        end else if (ctrl_en) begin
            presc_cnt <= tick ? 8'h0 : presc_cnt + 8'h1;
        end
    end

    // Sticky expiry flag, write-1-to-clear; a coincident expiry keeps it set.
    always_ff @(posedge pclk) begin
        if (preset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && pwdata[0]) begin
            expired <= 1'b0;
        end
    end

    // Registered interrupt level.
    always_ff @(posedge pclk) begin
        if (preset) begin
            irq <= 1'b0;
        end else begin
            irq <= expired & ctrl_irq_en;
        end
    end

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 1, number of PREADY-low cycles inserted in every ACCESS phase (0..7).
REQ-002 SHALL have port: pclk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: preset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: psel  input  1  slave select from APB master.
REQ-005 SHALL have port: penable  input  1  ACCESS-phase indicator.
REQ-006 SHALL have port: pwrite  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: paddr  input  12  byte address; only paddr[7:0] decoded.
REQ-008 SHALL have port: pwdata  input  32  write data.
REQ-009 SHALL have port: prdata  output  32  read data.
REQ-010 SHALL have port: pready  output  1  transfer-complete handshake.
REQ-011 SHALL have port: pslverr  output  1  error response for unmapped offset.
REQ-012 SHALL have port: irq  output  1  level timer interrupt.

Function
REQ-013 SHALL implement the register map CTRL 0x00 RW ([0] en, [1] auto_reload, [2] irq_en, [15:8] prescale, other bits read 0), LOAD 0x04 RW, COUNT 0x08 RO, and STATUS 0x0C ([0] expired, write-1-to-clear).
REQ-014 SHALL treat psel=1 with penable=0 as SETUP, which loads the wait counter with WAIT_STATES.
REQ-015 SHALL drive pready=0 in ACCESS while the wait counter is nonzero, decrementing it each cycle, and drive pready=1 when it reaches 0, so completion occurs WAIT_STATES cycles after ACCESS entry.
REQ-016 SHALL define completion as psel & penable & pready, and SHALL commit writes on the clock edge that ends the completion cycle.
REQ-017 SHALL drive prdata with the addressed register only during a read completion cycle, and 32'h0 at all other times.
REQ-018 SHALL assert pslverr only during completion of an access to an offset outside 0x00/0x04/0x08/0x0C or with paddr[1:0]!=0, and SHALL then ignore the write and return prdata=0.
REQ-019 SHALL ignore writes to COUNT without raising an error.
REQ-020 SHALL drive pready=1 and pslverr=0 when psel=0.
REQ-021 SHALL reload the wait counter if a new SETUP follows a completion back-to-back, with no idle cycle required.
REQ-022 SHALL, on a LOAD write, update both LOAD and COUNT to pwdata and clear the prescaler.
REQ-023 SHALL run an 8-bit prescaler only while en=1, generating tick when the prescaler equals prescale and then wrapping to 0, so prescale=0 gives a tick every cycle.
REQ-024 SHALL, on tick with COUNT!=0, decrement COUNT by 1.
REQ-025 SHALL, on tick with COUNT==0, set expired and then load COUNT with LOAD if auto_reload=1, or hold COUNT at 0 and clear en if auto_reload=0.
REQ-026 SHALL let the set win when a STATUS write-1-clear coincides with an expiry set in the same cycle.
REQ-027 SHALL give a COUNT read the value before that cycle's tick update.
REQ-028 SHALL let a LOAD write win over a same-cycle tick update of COUNT.
REQ-029 SHALL drive irq as the registered value of expired & irq_en, i.e. one cycle after the flag sets.
REQ-030 SHALL hold wait-counter behaviour if psel drops mid-ACCESS (protocol violation), returning to idle with no register update.

Reset
REQ-031 SHALL, while preset=1 at a clock edge, clear CTRL, LOAD, COUNT, STATUS, the prescaler, the wait counter and irq to 0.
REQ-032 SHALL hold outputs during reset at prdata=0, pready=1, pslverr=0, irq=0.
REQ-033 SHALL abort any in-progress transfer on reset without committing its write.
REQ-034 SHALL have no asynchronous reset path.

Verification
REQ-035 SHALL verify: with WAIT_STATES=1, write LOAD=5 -> pready low for 1 ACCESS cycle then high; a subsequent COUNT read returns 5.
REQ-036 SHALL verify: CTRL=0x0000_0005 (en, irq_en, prescale 0) with LOAD=3 -> COUNT steps 3,2,1,0; expired sets on the next tick; irq rises 1 cycle later; en reads 0.
REQ-037 SHALL verify: CTRL=0x0000_0203 (auto_reload, prescale 2) with LOAD=1 -> COUNT changes every 3 cycles and reloads to 1 after reaching 0; expired sets every 6 cycles.
REQ-038 SHALL verify: read of offset 0x10 -> pslverr=1 and prdata=0 in the completion cycle; a write to 0x10 leaves all registers unchanged.
REQ-039 SHALL verify: STATUS write 0x1 in the same cycle as an expiry -> expired stays 1; a later STATUS write 0x1 clears it and irq drops the next cycle.
REQ-040 SHALL verify: preset asserted mid-ACCESS of a LOAD write 0xFFFF_FFFF -> LOAD=0 after reset, pready=1, irq=0.
